// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Expands one macro-op into the ALU micro-instruction stream,
//               drives operands on the shared bus and captures R/FLAG back.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int RD_WAIT = 0
) (
    input  logic       clk,
    input  logic       grst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    input  logic [3:0] op_sel,
    output logic [3:0] instr,
    inout  wire  [3:0] bus,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [3:0] res_flag,
    output logic       res_err
);

    localparam logic [2:0] c_OP_ADD     = 3'd0;
    localparam logic [2:0] c_OP_SUB     = 3'd1;
    localparam logic [2:0] c_OP_LOGIC   = 3'd2;
    localparam logic [2:0] c_OP_ADD_ACC = 3'd3;
    localparam logic [2:0] c_OP_SUB_ACC = 3'd4;
    localparam logic [2:0] c_OP_CLEAR   = 3'd5;

    localparam logic [3:0] c_I_NOP   = 4'h0;
    localparam logic [3:0] c_I_LD1   = 4'h1;
    localparam logic [3:0] c_I_LD2   = 4'h2;
    localparam logic [3:0] c_I_LD3   = 4'h3;
    localparam logic [3:0] c_I_LOGIC = 4'h4;
    localparam logic [3:0] c_I_ADD   = 4'h5;
    localparam logic [3:0] c_I_SUB   = 4'h6;
    localparam logic [3:0] c_I_RD_R  = 4'h7;
    localparam logic [3:0] c_I_RD_F  = 4'h8;
    localparam logic [3:0] c_I_R2X1  = 4'h9;
    localparam logic [3:0] c_I_CLEAR = 4'hF;

    localparam logic [7:0] c_WAIT_INIT = 8'(RD_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LD1, S_LD2, S_LD3, S_ACC, S_EXE,
        S_WAIT_R, S_RDR, S_WAIT_F, S_RDF, S_CLR, S_DONE
    } state_t;

    state_t     r_state;
    logic [2:0] r_code;
    logic [3:0] r_b;
    logic [3:0] r_sel;
    logic [3:0] r_instr;
    logic [3:0] r_bus_out;
    logic       r_bus_oe;
    logic [7:0] r_wait_cnt;
    logic [3:0] w_exe_instr;

    assign instr    = r_instr;
    assign bus      = r_bus_oe ? r_bus_out : 4'bzzzz;
    assign op_ready = (r_state == S_IDLE) && !grst;

    always_comb begin
        w_exe_instr = c_I_ADD;
        case (r_code)
            c_OP_SUB, c_OP_SUB_ACC: w_exe_instr = c_I_SUB;
            c_OP_LOGIC:             w_exe_instr = c_I_LOGIC;
            default:                w_exe_instr = c_I_ADD;
        endcase
    end

    // instr and bus drive default to NOP/released; only issue cycles override.
    always_ff @(posedge clk or posedge grst) begin
        if (grst) begin
            r_state    <= S_IDLE;
            r_code     <= 3'd0;
            r_b        <= 4'd0;
            r_sel      <= 4'd0;
            r_instr    <= c_I_NOP;
            r_bus_out  <= 4'd0;
            r_bus_oe   <= 1'b0;
            r_wait_cnt <= 8'd0;
            res_valid  <= 1'b0;
            res_data   <= 4'd0;
            res_flag   <= 4'd0;
            res_err    <= 1'b0;
        end else begin
            r_instr  <= c_I_NOP;
            r_bus_oe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_code <= op_code;
                        r_b    <= op_b;
                        r_sel  <= op_sel;
                        case (op_code)
                            c_OP_ADD, c_OP_SUB, c_OP_LOGIC: begin
                                r_state   <= S_LD1;
                                r_instr   <= c_I_LD1;
                                r_bus_out <= op_a;
                                r_bus_oe  <= 1'b1;
                            end
                            c_OP_ADD_ACC, c_OP_SUB_ACC: begin
                                r_state <= S_ACC;
                                r_instr <= c_I_R2X1;
                            end
                            c_OP_CLEAR: begin
                                r_state <= S_CLR;
                                r_instr <= c_I_CLEAR;
                            end
                            default: begin
                                r_state   <= S_DONE;
                                res_valid <= 1'b1;
                                res_err   <= 1'b1;
                                res_data  <= 4'd0;
                                res_flag  <= 4'd0;
                            end
                        endcase
                    end
                end
                S_LD1, S_ACC: begin
                    r_state   <= S_LD2;
                    r_instr   <= c_I_LD2;
                    r_bus_out <= r_b;
                    r_bus_oe  <= 1'b1;
                end
                S_LD2: begin
                    if (r_code == c_OP_LOGIC) begin
                        r_state   <= S_LD3;
                        r_instr   <= c_I_LD3;
                        r_bus_out <= r_sel;
                        r_bus_oe  <= 1'b1;
                    end else begin
                        r_state <= S_EXE;
                        r_instr <= w_exe_instr;
                    end
                end
                S_LD3: begin
                    r_state <= S_EXE;
                    r_instr <= w_exe_instr;
                end
                S_EXE: begin
                    if (RD_WAIT == 0) begin
                        r_state <= S_RDR;
                        r_instr <= c_I_RD_R;
                    end else begin
                        r_state    <= S_WAIT_R;
                        r_wait_cnt <= c_WAIT_INIT;
                    end
                end
                S_WAIT_R: begin
                    if (r_wait_cnt == 8'd0) begin
                        r_state <= S_RDR;
                        r_instr <= c_I_RD_R;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end
                end
                S_RDR: begin
                    // ALU drives R combinationally during this cycle
                    res_data <= bus;
                    if (RD_WAIT == 0) begin
                        r_state <= S_RDF;
                        r_instr <= c_I_RD_F;
                    end else begin
                        r_state    <= S_WAIT_F;
                        r_wait_cnt <= c_WAIT_INIT;
                    end
                end
                S_WAIT_F: begin
                    if (r_wait_cnt == 8'd0) begin
                        r_state <= S_RDF;
                        r_instr <= c_I_RD_F;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 8'd1;
                    end
                end
                S_RDF: begin
                    res_flag  <= bus;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_CLR: begin
                    res_data  <= 4'd0;
                    res_flag  <= 4'd0;
                    res_err   <= 1'b0;
                    res_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed bench for alu_sequencer with a behavioural ALU on the bus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       grst;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [3:0] op_sel;
    logic [3:0] instr;
    wire  [3:0] bus;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [3:0] res_flag;
    logic       res_err;

    int errors = 0;
    int checks = 0;

    // A released bus floats high, so "not driven" reads as 4'hF.
    pullup (bus[0]);
    pullup (bus[1]);
    pullup (bus[2]);
    pullup (bus[3]);

    alu_sequencer #(.RD_WAIT(0)) dut (
        .clk       (clk),
        .grst      (grst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .instr     (instr),
        .bus       (bus),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: FLAG = {carry/borrow, zero, negative, parity}
    logic [3:0] x1, x2, x3, alu_r, alu_f;
    logic [4:0] t;

    function automatic logic [3:0] mkflag(input logic c, input logic [3:0] v);
        return {c, (v == 4'd0), v[3], ^v};
    endfunction

    function automatic logic [3:0] lg(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        case (s)
            4'd1: return a & b;
            4'd2: return a | b;
            4'd3: return a ^ b;
            4'd4: return ~(a & b);
            4'd5: return ~(a | b);
            4'd6: return ~(a ^ b);
            4'd7: return ~a;
            default: return a;
        endcase
    endfunction

    always @(posedge clk or posedge grst) begin
        if (grst) begin
            x1 <= 4'd0; x2 <= 4'd0; x3 <= 4'd0; alu_r <= 4'd0; alu_f <= 4'd0;
        end else begin
            case (instr)
                4'h1: x1 <= bus;
                4'h2: x2 <= bus;
                4'h3: x3 <= bus;
                4'h4: begin
                    alu_r <= lg(x1, x2, x3);
                    alu_f <= mkflag(1'b0, lg(x1, x2, x3));
                end
                4'h5: begin
                    t = {1'b0, x1} + {1'b0, x2};
                    alu_r <= t[3:0];
                    alu_f <= mkflag(t[4], t[3:0]);
                end
                4'h6: begin
                    t = {1'b0, x1} - {1'b0, x2};
                    alu_r <= t[3:0];
                    alu_f <= mkflag(t[4], t[3:0]);
                end
                4'h9: x1 <= alu_r;
                4'hF: begin
                    x1 <= 4'd0; x2 <= 4'd0; x3 <= 4'd0; alu_r <= 4'd0; alu_f <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus = (instr == 4'h7) ? alu_r : (instr == 4'h8) ? alu_f : 4'bzzzz;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] code, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] sel);
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b; op_sel = sel;
        chk("op_ready_idle", {7'd0, op_ready}, 8'd1);
        tick();
        op_valid = 1'b0; op_a = 4'hE; op_b = 4'hE; op_sel = 4'hE;
    endtask

    task automatic step(input string tag, input logic [3:0] ei, input logic [3:0] eb);
        chk({tag, "_instr"}, {4'd0, instr}, {4'd0, ei});
        chk({tag, "_bus"}, {4'd0, bus}, {4'd0, eb});
        chk({tag, "_busy"}, {6'd0, op_ready, res_valid}, 8'd0);
        tick();
    endtask

    task automatic done(input string tag, input logic [3:0] ed, input logic [3:0] ef,
                        input logic ee);
        chk({tag, "_valid"}, {7'd0, res_valid}, 8'd1);
        chk({tag, "_data"}, {4'd0, res_data}, {4'd0, ed});
        chk({tag, "_flag"}, {4'd0, res_flag}, {4'd0, ef});
        chk({tag, "_err"}, {7'd0, res_err}, {7'd0, ee});
        chk({tag, "_instr"}, {4'd0, instr}, 8'd0);
        chk({tag, "_bus"}, {4'd0, bus}, 8'hF);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_hs_valid"}, {7'd0, res_valid}, 8'd0);
        chk({tag, "_hs_ready"}, {7'd0, op_ready}, 8'd1);
    endtask

    logic [3:0] exp_logic_r [1:7];
    logic [3:0] exp_logic_f [1:7];

    initial begin
        exp_logic_r = '{4'h0, 4'h5, 4'h5, 4'hF, 4'hA, 4'hA, 4'hB};
        exp_logic_f = '{4'h4, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h3};
        grst = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_a = 4'd0; op_b = 4'd0;
        op_sel = 4'd0; res_ready = 1'b0;
        tick(); tick();
        chk("rst_instr", {4'd0, instr}, 8'd0);
        chk("rst_bus", {4'd0, bus}, 8'hF);
        chk("rst_ready", {7'd0, op_ready}, 8'd0);
        chk("rst_res", {res_valid, res_err, 2'd0, res_data}, 8'd0);
        chk("rst_flag", {4'd0, res_flag}, 8'd0);
        grst = 1'b0;
        tick();

        // 1: ADD 4+1
        issue(3'd0, 4'h4, 4'h1, 4'h0);
        step("add_ld1", 4'h1, 4'h4);
        step("add_ld2", 4'h2, 4'h1);
        step("add_exe", 4'h5, 4'hF);
        step("add_rdr", 4'h7, 4'h5);
        step("add_rdf", 4'h8, 4'h0);
        done("add", 4'h5, 4'h0, 1'b0);
        handshake("add");

        // 2: LOGIC 4,1 with sel 1..7 back-to-back
        for (int s = 1; s <= 7; s++) begin
            issue(3'd2, 4'h4, 4'h1, 4'(s));
            step("lg_ld1", 4'h1, 4'h4);
            step("lg_ld2", 4'h2, 4'h1);
            step("lg_ld3", 4'h3, 4'(s));
            step("lg_exe", 4'h4, 4'hF);
            step("lg_rdr", 4'h7, exp_logic_r[s]);
            step("lg_rdf", 4'h8, exp_logic_f[s]);
            done("lg", exp_logic_r[s], exp_logic_f[s], 1'b0);
            handshake("lg");
        end

        // 3: SUB 1-4 then SUB_ACC with b=1
        issue(3'd1, 4'h1, 4'h4, 4'h0);
        step("sub_ld1", 4'h1, 4'h1);
        step("sub_ld2", 4'h2, 4'h4);
        step("sub_exe", 4'h6, 4'hF);
        step("sub_rdr", 4'h7, 4'hD);
        step("sub_rdf", 4'h8, 4'hB);
        done("sub", 4'hD, 4'hB, 1'b0);
        handshake("sub");
        issue(3'd4, 4'h7, 4'h1, 4'h0);
        step("sacc_acc", 4'h9, 4'hF);
        step("sacc_ld2", 4'h2, 4'h1);
        step("sacc_exe", 4'h6, 4'hF);
        step("sacc_rdr", 4'h7, 4'hC);
        step("sacc_rdf", 4'h8, 4'h2);
        done("sacc", 4'hC, 4'h2, 1'b0);
        handshake("sacc");

        // 4: consumer stalls for 5 cycles; a new request meanwhile is ignored
        issue(3'd0, 4'h2, 4'h3, 4'h0);
        step("stl_ld1", 4'h1, 4'h2);
        step("stl_ld2", 4'h2, 4'h3);
        step("stl_exe", 4'h5, 4'hF);
        step("stl_rdr", 4'h7, 4'h5);
        step("stl_rdf", 4'h8, 4'h0);
        op_valid = 1'b1; op_code = 3'd0; op_a = 4'h9; op_b = 4'h9;
        for (int k = 0; k < 5; k++) begin
            done("stl_hold", 4'h5, 4'h0, 1'b0);
            chk("stl_ready", {7'd0, op_ready}, 8'd0);
            tick();
        end
        op_valid = 1'b0;
        handshake("stl");
        chk("stl_idle_instr", {4'd0, instr}, 8'd0);

        // 5: CLEAR, then illegal opcode
        issue(3'd5, 4'h0, 4'h0, 4'h0);
        step("clr", 4'hF, 4'hF);
        done("clr", 4'h0, 4'h0, 1'b0);
        handshake("clr");
        issue(3'd6, 4'h3, 4'h3, 4'h3);
        done("ill", 4'h0, 4'h0, 1'b1);
        handshake("ill");
        chk("ill_err_kept", {7'd0, res_err}, 8'd1);

        // 6: reset during LD2, then a clean ADD 3+9
        issue(3'd0, 4'h4, 4'h1, 4'h0);
        step("rst_ld1", 4'h1, 4'h4);
        chk("rst_ld2_instr", {4'd0, instr}, 8'h2);
        grst = 1'b1;
        #1;
        chk("abort_instr", {4'd0, instr}, 8'd0);
        chk("abort_bus", {4'd0, bus}, 8'hF);
        chk("abort_valid", {7'd0, res_valid}, 8'd0);
        tick();
        grst = 1'b0;
        tick();
        chk("abort_ready", {7'd0, op_ready}, 8'd1);
        issue(3'd0, 4'h3, 4'h9, 4'h0);
        step("re_ld1", 4'h1, 4'h3);
        step("re_ld2", 4'h2, 4'h9);
        step("re_exe", 4'h5, 4'hF);
        step("re_rdr", 4'h7, 4'hC);
        step("re_rdf", 4'h8, 4'h2);
        done("re", 4'hC, 4'h2, 1'b0);
        handshake("re");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
